// File: rtl/spi_prefetch_fifo.sv
// rtl/spi_prefetch_fifo.sv - read-ahead word buffer between the SPI flash reader and the decoder
// Optional empty-buffer fall-through, early stall request, sticky overflow and stream flush.
module spi_prefetch_fifo #(
    parameter int DATA_WIDTH_BYTES = 4,
    parameter int DEPTH            = 4,
    parameter int STALL_MARGIN     = 1,
    parameter int FALLTHROUGH      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                in_valid,
    input  logic [DATA_WIDTH_BYTES*8-1:0]       in_data,
    output logic                                in_ready,
    output logic                                spi_stall,
    output logic                                out_valid,
    output logic [DATA_WIDTH_BYTES*8-1:0]       out_data,
    input  logic                                out_ready,
    output logic [$clog2(DEPTH+1)-1:0]          level,
    output logic                                overflow
);

    localparam int W  = DATA_WIDTH_BYTES * 8;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(DEPTH);
    localparam logic [LW-1:0] STALL_LEVEL = LW'(DEPTH - STALL_MARGIN);
    localparam logic          FT          = (FALLTHROUGH != 0);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          empty;
    logic          bypass;
    logic          push;
    logic          pop;
    logic          drop;

    assign empty     = (level == '0);
    assign in_ready  = (level < FULL_LEVEL);
    assign spi_stall = (level >= STALL_LEVEL);
    assign out_valid = !empty || (FT && in_valid);
    assign out_data  = (!empty || !FT) ? mem[rp] : in_data;

    // A word handed straight to the consumer never touches the array.
    assign bypass = FT && empty && in_valid && out_ready;
    assign push   = in_valid && in_ready && !bypass;
    assign pop    = out_ready && !empty;
    assign drop   = in_valid && !in_ready;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wp] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_prefetch_fifo.sv
// tb/tb_spi_prefetch_fifo.sv - directed vector bench for spi_prefetch_fifo
module tb_spi_prefetch_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        f_flush = 1'b0, f_in_valid = 1'b0, f_out_ready = 1'b0;
    logic [31:0] f_in_data = '0;
    logic        f_in_ready, f_spi_stall, f_out_valid, f_overflow;
    logic [31:0] f_out_data;
    logic [2:0]  f_level;

    logic        r_flush = 1'b0, r_in_valid = 1'b0, r_out_ready = 1'b0;
    logic [31:0] r_in_data = '0;
    logic        r_in_ready, r_spi_stall, r_out_valid, r_overflow;
    logic [31:0] r_out_data;
    logic [2:0]  r_level;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    spi_prefetch_fifo #(.DATA_WIDTH_BYTES(4), .DEPTH(4), .STALL_MARGIN(1), .FALLTHROUGH(1)) u_ft (
        .clk(clk), .rst(rst), .flush(f_flush),
        .in_valid(f_in_valid), .in_data(f_in_data), .in_ready(f_in_ready),
        .spi_stall(f_spi_stall), .out_valid(f_out_valid), .out_data(f_out_data),
        .out_ready(f_out_ready), .level(f_level), .overflow(f_overflow)
    );

    spi_prefetch_fifo #(.DATA_WIDTH_BYTES(4), .DEPTH(4), .STALL_MARGIN(1), .FALLTHROUGH(0)) u_reg (
        .clk(clk), .rst(rst), .flush(r_flush),
        .in_valid(r_in_valid), .in_data(r_in_data), .in_ready(r_in_ready),
        .spi_stall(r_spi_stall), .out_valid(r_out_valid), .out_data(r_out_data),
        .out_ready(r_out_ready), .level(r_level), .overflow(r_overflow)
    );

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        fl;
        logic        e_ovalid;
        logic [31:0] e_odata;
        int          e_level;
        logic        e_irdy;
        logic        e_stall;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [31:0] din, input logic ordy, input logic fl,
                       input logic e_ovalid, input logic [31:0] e_odata, input int e_level,
                       input logic e_irdy, input logic e_stall, input logic e_ovf);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
        v.e_ovalid = e_ovalid; v.e_odata = e_odata; v.e_level = e_level;
        v.e_irdy = e_irdy; v.e_stall = e_stall; v.e_ovf = e_ovf;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, got, exp);
        end else begin
            passed++;
        end
    endtask

    initial begin
        // inputs: iv, data, out_ready, flush | comb: out_valid, out_data | after edge: level, in_ready, stall, overflow
        add(1, 32'hA5A5_0001, 1, 0, 1, 32'hA5A5_0001, 0, 1, 0, 0);
        add(1, 32'h11, 0, 0, 1, 32'h11, 1, 1, 0, 0);
        add(1, 32'h22, 0, 0, 1, 32'h11, 2, 1, 0, 0);
        add(1, 32'h33, 0, 0, 1, 32'h11, 3, 1, 1, 0);
        add(1, 32'h44, 0, 0, 1, 32'h11, 4, 0, 1, 0);
        add(0, 32'h0,  1, 0, 1, 32'h11, 3, 1, 1, 0);
        add(0, 32'h0,  1, 0, 1, 32'h22, 2, 1, 0, 0);
        add(0, 32'h0,  1, 0, 1, 32'h33, 1, 1, 0, 0);
        add(0, 32'h0,  1, 0, 1, 32'h44, 0, 1, 0, 0);
        add(0, 32'h0,  0, 0, 0, 32'h0,  0, 1, 0, 0);
        add(1, 32'h1,  0, 0, 1, 32'h1,  1, 1, 0, 0);
        add(1, 32'h2,  0, 0, 1, 32'h1,  2, 1, 0, 0);
        add(1, 32'h3,  0, 0, 1, 32'h1,  3, 1, 1, 0);
        add(1, 32'h4,  0, 0, 1, 32'h1,  4, 0, 1, 0);
        add(1, 32'h55, 1, 0, 1, 32'h1,  3, 1, 1, 1);
        add(0, 32'h0,  1, 0, 1, 32'h2,  2, 1, 0, 1);
        add(1, 32'h100, 1, 0, 1, 32'h3,   2, 1, 0, 1);
        add(1, 32'h101, 1, 0, 1, 32'h4,   2, 1, 0, 1);
        add(1, 32'h102, 1, 0, 1, 32'h100, 2, 1, 0, 1);
        add(1, 32'h103, 1, 0, 1, 32'h101, 2, 1, 0, 1);
        add(1, 32'h104, 1, 0, 1, 32'h102, 2, 1, 0, 1);
        add(1, 32'h105, 1, 0, 1, 32'h103, 2, 1, 0, 1);
        add(1, 32'h106, 0, 0, 1, 32'h104, 3, 1, 1, 1);
        add(1, 32'h77,  1, 1, 1, 32'h104, 0, 1, 0, 0);
        add(0, 32'h0,   0, 0, 0, 32'h0,   0, 1, 0, 0);

        @(posedge clk); #1;
        chk("reset_level",    -1, 32'(f_level), 32'd0);
        chk("reset_in_ready", -1, 32'(f_in_ready), 32'd1);
        chk("reset_overflow", -1, 32'(f_overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset_stall",     -1, 32'(f_spi_stall), 32'd0);
        chk("reset_out_valid", -1, 32'(f_out_valid), 32'd0);

        foreach (vecs[i]) begin
            f_in_valid  = vecs[i].iv;
            f_in_data   = vecs[i].din;
            f_out_ready = vecs[i].ordy;
            f_flush     = vecs[i].fl;
            #2;
            chk("out_valid", i, 32'(f_out_valid), 32'(vecs[i].e_ovalid));
            if (vecs[i].e_ovalid) chk("out_data", i, f_out_data, vecs[i].e_odata);
            @(posedge clk); #1;
            chk("level",    i, 32'(f_level), 32'(vecs[i].e_level));
            chk("in_ready", i, 32'(f_in_ready), 32'(vecs[i].e_irdy));
            chk("stall",    i, 32'(f_spi_stall), 32'(vecs[i].e_stall));
            chk("overflow", i, 32'(f_overflow), 32'(vecs[i].e_ovf));
        end
        f_in_valid = 1'b0; f_out_ready = 1'b0; f_flush = 1'b0;

        // Registered path: no same-cycle visibility, one cycle latency.
        r_in_valid = 1'b1; r_in_data = 32'hDEAD_BEEF; r_out_ready = 1'b0;
        #2;
        chk("reg_out_valid_same_cycle", 0, 32'(r_out_valid), 32'd0);
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        #1;
        chk("reg_out_valid_next", 1, 32'(r_out_valid), 32'd1);
        chk("reg_out_data_next",  1, r_out_data, 32'hDEAD_BEEF);
        r_in_valid = 1'b1; r_in_data = 32'h0000_0002;
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        chk("reg_level_two", 2, 32'(r_level), 32'd2);
        chk("reg_head_kept", 2, r_out_data, 32'hDEAD_BEEF);

        // Asynchronous reset in the middle of the cycle.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_level",     3, 32'(r_level), 32'd0);
        chk("async_rst_out_valid", 3, 32'(r_out_valid), 32'd0);
        chk("async_rst_in_ready",  3, 32'(r_in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_level", 4, 32'(r_level), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_prefetch_fifo.md
# spi_prefetch_fifo

Parametrised read-ahead buffer between the SPI flash streaming reader and the pixel/RLE decoder. It holds up to DEPTH completed SPI words, so the reader can run ahead of the consumer. An optional fall-through path lets a word arriving into an empty buffer reach the consumer in the same cycle. The block drives a stall request back to the SPI reader before it fills, and supports a flush that restarts the stream on a new read address.

## Interface
- DATA_WIDTH_BYTES, 4, word width in bytes; W = DATA_WIDTH_BYTES*8
- DEPTH, 4, storage entries; power of two, ≥ 2
- STALL_MARGIN, 1, stall asserted when level ≥ DEPTH − STALL_MARGIN; range 0..DEPTH−1
- FALLTHROUGH, 1, 1 = empty-buffer bypass enabled, 0 = every word registered first
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all contents and clear flags; asserted with each new SPI read command
- in_valid  in  1  SPI reader presents a completed word this cycle
- in_data  in  W  word from SPI reader
- in_ready  out  1  entry free; (level < DEPTH), registered-state only, no path from out_ready
- spi_stall  out  1  request SPI reader to pause clocking after the current word
- out_valid  out  1  out_data holds a valid word
- out_data  out  W  head word
- out_ready  in  1  consumer pops head when out_valid
- level  out  $clog2(DEPTH+1)  number of stored words (bypassed words not counted)
- overflow  out  1  sticky: a word was offered while in_ready=0 and was dropped

## Operation
- Storage: DEPTH×W register array, write pointer wp and read pointer rp, both log2(DEPTH) bits, wrapping modulo DEPTH; level is an explicit counter 0..DEPTH.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = (level > 0) | (FALLTHROUGH & in_valid).
- out_data = array[rp] when level > 0; otherwise in_data (when FALLTHROUGH=1); otherwise don't-care, held at array[rp].
- Bypass case: level = 0, FALLTHROUGH=1, in_valid & out_ready → word consumed directly; no write, pointers and level unchanged.
- Otherwise push writes array[wp], wp+1; pop increments rp; level += push − pop.
- Simultaneous push and pop at 0 < level < DEPTH: level unchanged, both pointers advance.
- Full (level = DEPTH): in_ready = 0; in_valid this cycle is dropped, overflow ← 1. A same-cycle pop does not rescue the word.
- Empty with FALLTHROUGH=0: out_valid = 0; a pushed word appears as out_valid the next cycle.
- spi_stall = (level ≥ DEPTH − STALL_MARGIN); combinational from level only.
- flush has priority over push, pop and overflow: next state is level=0, wp=rp=0, overflow=0. in_valid or out_ready in the flush cycle has no effect. out_valid in the flush cycle still follows the current state; the consumer must ignore it.
- overflow is cleared only by flush or rst.

## Timing
- Reset (async assert, released synchronously by top-level synchroniser): level=0, wp=rp=0, overflow=0. Resulting outputs: out_valid=in_valid&FALLTHROUGH, in_ready=1, spi_stall=(STALL_MARGIN==DEPTH ? 1 : 0), which is 0 for legal parameter values.
- Reset mid-stream discards all contents immediately, without waiting for a clock.
- Latency in→out: 0 cycles via bypass when empty (FALLTHROUGH=1); 1 cycle when registered.
- Pop takes effect on the clock edge; the next head appears on out_data the following cycle.
- The SPI reader must stop issuing words within STALL_MARGIN words of spi_stall rising. Words beyond that margin set overflow.

## Test plan
- Reset, FALLTHROUGH=1, DEPTH=4: drive in_valid=1, in_data=0xA5A5_0001, out_ready=1 in one cycle → out_valid=1, out_data=0xA5A5_0001 in that cycle; level stays 0.
- Push 0x11,0x22,0x33 with out_ready=0 → level=3 and spi_stall=1 after the third edge (STALL_MARGIN=1); push 0x44 → level=4, in_ready=0; pop four times → 0x11,0x22,0x33,0x44 in order, then level=0.
- Full (level=4): assert in_valid with 0x55 and out_ready together → 0x55 dropped, overflow=1, level=3; the next pop returns the second-oldest word.
- Level=2: assert push and pop simultaneously for 6 cycles with an incrementing pattern → level stays 2, pointers wrap, and output order is preserved.
- Level=3, overflow=1: assert flush with in_valid=1 and out_ready=1 → next cycle level=0, overflow=0, spi_stall=0; the in_valid word is not stored.
- FALLTHROUGH=0: push 0xDEAD_BEEF into empty buffer → out_valid=0 that cycle, out_valid=1 with 0xDEAD_BEEF the next cycle; assert rst asynchronously mid-cycle with level=2 → level=0 immediately.
